// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, read-modify-write for sub-doubleword stores.
// Optional LSU_MISALIGN_TRAP_EN rejects accesses whose address is not a multiple of their size.
module lsu_ctrl #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic        mem_wen_o,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        StIdle,
        StLdRd,
        StStRd,
        StStWr,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] old_q, old_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  req_size;
    logic [64:0] req_end;
    logic        req_illegal;
    logic        req_oor;
    logic        req_misalign;
    logic        req_bad;

    logic [3:0]  size_q;
    logic [63:0] load_ext;
    logic [63:0] store_merge;

    // Request classification, evaluated on the incoming request in IDLE
    always_comb begin
        req_size    = 4'd1 << req_funct3_i[1:0];
        req_end     = {1'b0, req_addr_i} + 65'(req_size);
        req_illegal = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
        req_oor     = req_end > 65'(ADDR_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        req_misalign = (req_addr_i[2:0] & 3'(req_size - 4'd1)) != 3'b000;
`else
        req_misalign = 1'b0;
`endif
        req_bad = req_illegal || req_oor || req_misalign;
    end

    always_comb begin
        load_ext = '0;
        unique case (funct3_q)
            3'b000:  load_ext = {{56{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            3'b001:  load_ext = {{48{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            3'b010:  load_ext = {{32{mem_rdata_i[31]}}, mem_rdata_i[31:0]};
            3'b011:  load_ext = mem_rdata_i;
            3'b100:  load_ext = {56'd0, mem_rdata_i[7:0]};
            3'b101:  load_ext = {48'd0, mem_rdata_i[15:0]};
            3'b110:  load_ext = {32'd0, mem_rdata_i[31:0]};
            default: load_ext = '0;
        endcase
    end

    // Little-endian byte merge: the low size_q bytes come from the store data
    always_comb begin
        size_q      = 4'd1 << funct3_q[1:0];
        store_merge = old_q;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(size_q)) begin
                store_merge[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wen_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = !rst_i;
                if (req_valid_i) begin
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = '0;
                    err_d    = req_bad;
                    if (req_bad) begin
                        state_d = StResp;
                    end else if (!req_we_i) begin
                        state_d = StLdRd;
                    end else if (req_funct3_i[1:0] == 2'b11) begin
                        state_d = StStWr;
                    end else begin
                        state_d = StStRd;
                    end
                end
            end
            StLdRd: begin
                mem_addr_o = addr_q;
                rdata_d    = load_ext;
                state_d    = StResp;
            end
            StStRd: begin
                mem_addr_o = addr_q;
                old_d      = mem_rdata_i;
                state_d    = StStWr;
            end
            StStWr: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = store_merge;
                mem_wen_o   = !rst_i;
                state_d     = StResp;
            end
            StResp: begin
                resp_valid_o = !rst_i;
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Present reset values on the RAM port while reset is held
        if (rst_i) begin
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver queues expected responses, a monitor checks them.
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_wen_o;
    logic [63:0] mem_rdata_i;

    lsu_ctrl #(.ADDR_LIMIT(1024)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_funct3_i(req_funct3_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o),
        .resp_err_o  (resp_err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wen_o   (mem_wen_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Byte-addressed RAM model with a little slack past the limit for 8-byte windows
    logic [7:0] ram [0:1031];

    always_comb begin
        logic [63:0] a;
        mem_rdata_i = '0;
        for (int i = 0; i < 8; i++) begin
            a = mem_addr_o + 64'(i);
            mem_rdata_i[8*i +: 8] = (a < 64'd1032) ? ram[a[10:0]] : 8'h00;
        end
    end

    always @(posedge clk_i) begin
        if (mem_wen_o) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_addr_o + 64'(i) < 64'd1032) ram[11'(mem_addr_o + 64'(i))] <= mem_wdata_o[8*i +: 8];
            end
        end
    end

    typedef struct {
        string       name;
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          acc;
        int          wen0;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   wen_cnt  = 0;
    bit   seen     = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on first valid, payload and write count on handshake
    always @(negedge clk_i) begin
        if (mem_wen_o) wen_cnt++;
        if (resp_valid_o) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid_o), 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check({q[0].name, "_latency"}, 64'(cyc - q[0].acc), 64'(q[0].lat));
                end
                if (resp_ready_i) begin
                    check({q[0].name, "_err"}, 64'(resp_err_o), 64'(q[0].err));
                    check({q[0].name, "_rdata"}, resp_rdata_o, q[0].rdata);
                    check({q[0].name, "_wen"}, 64'(wen_cnt - q[0].wen0), 64'(q[0].err ? 0 :
                          (q[0].lat == 0 ? 0 : (q[0].name.substr(0, 0) == "S" ? 1 : 0))));
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // lat is the number of edges after the accept edge before resp_valid_o rises
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic e_err, input logic [63:0] e_rdata, input int lat);
        exp_t e;
        int   w;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        w = 0;
        while (!req_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (w == 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: req_ready_o never rose within 50 cycles", name);
        end
        e.name  = name;
        e.err   = e_err;
        e.rdata = e_rdata;
        e.lat   = lat;
        e.acc   = cyc + 1;
        e.wen0  = wen_cnt;
        q.push_back(e);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (q.size() != 0 && w < 40) begin
            @(negedge clk_i);
            w++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
            q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic req(input string name, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic e_err, input logic [63:0] e_rdata, input int lat);
        issue(name, we, f3, addr, wdata, e_err, e_rdata, lat);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 1032; i++) ram[i] = 8'h00;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        resp_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_err", 64'(resp_err_o), 64'd0);
        check("rst_resp_rdata", resp_rdata_o, 64'd0);
        check("rst_mem_wen", 64'(mem_wen_o), 64'd0);
        check("rst_mem_addr", mem_addr_o, 64'd0);
        check("rst_mem_wdata", mem_wdata_o, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_req_ready", 64'(req_ready_o), 64'd1);

        // Names starting with S are stores that must write RAM exactly once
        req("SD_10", 1, 3'b011, 64'h10, 64'h1122334455667788, 0, 64'h0, 1);
        req("LD_10", 0, 3'b011, 64'h10, 64'h0, 0, 64'h1122334455667788, 1);
        req("SB_12", 1, 3'b000, 64'h12, 64'hAB, 0, 64'h0, 2);
        req("LD_10b", 0, 3'b011, 64'h10, 64'h0, 0, 64'h1122334455AB7788, 1);
        req("SB_13", 1, 3'b000, 64'h13, 64'hF0, 0, 64'h0, 2);
        req("LB_13", 0, 3'b000, 64'h13, 64'h0, 0, 64'hFFFFFFFFFFFFFFF0, 1);
        req("LBU_13", 0, 3'b100, 64'h13, 64'h0, 0, 64'h00000000000000F0, 1);
        req("SW_20", 1, 3'b010, 64'h20, 64'hDEAD_BEEF_8000_0000, 0, 64'h0, 2);
        req("LWU_20", 0, 3'b110, 64'h20, 64'h0, 0, 64'h0000000080000000, 1);
        req("LW_20", 0, 3'b010, 64'h20, 64'h0, 0, 64'hFFFFFFFF80000000, 1);
        req("LD_20", 0, 3'b011, 64'h20, 64'h0, 0, 64'h0000000080000000, 1);
        req("LH_22", 0, 3'b001, 64'h22, 64'h0, 0, 64'hFFFFFFFFFFFF8000, 1);
        req("LHU_22", 0, 3'b101, 64'h22, 64'h0, 0, 64'h0000000000008000, 1);
        req("SH_30", 1, 3'b001, 64'h30, 64'hFFFF_1234, 0, 64'h0, 2);
        req("LD_30", 0, 3'b011, 64'h30, 64'h0, 0, 64'h0000000000001234, 1);
        req("LD_3FC_oor", 0, 3'b011, 64'h3FC, 64'h0, 1, 64'h0, 0);
        req("LD_3F8_edge", 0, 3'b011, 64'h3F8, 64'h0, 0, 64'h0, 1);
        req("SB_3FF_edge", 1, 3'b000, 64'h3FF, 64'h5A, 0, 64'h0, 2);
        req("LBU_3FF", 0, 3'b100, 64'h3FF, 64'h0, 0, 64'h5A, 1);
        req("SB_400_oor", 1, 3'b000, 64'h400, 64'h5A, 1, 64'h0, 0);
        req("SBU_ill", 1, 3'b100, 64'h10, 64'h55, 1, 64'h0, 0);
        req("L111_ill", 0, 3'b111, 64'h10, 64'h0, 1, 64'h0, 0);
        req("LD_wrap", 0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, 1, 64'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        req("LW_11_mis", 0, 3'b010, 64'h11, 64'h0, 1, 64'h0, 0);
`else
        req("LW_11_mis", 0, 3'b010, 64'h11, 64'h0, 0, 64'h0000000044F0AB77, 1);
`endif

        // Response stall: held for 5 cycles with outputs stable
        resp_ready_i = 1'b0;
        issue("LD_stall", 0, 3'b011, 64'h10, 64'h0, 0, 64'h11223344F0AB7788, 1);
        begin
            int w;
            w = 0;
            while (!resp_valid_o && w < 20) begin
                @(negedge clk_i);
                w++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_valid", 64'(resp_valid_o), 64'd1);
            check("stall_req_ready", 64'(req_ready_o), 64'd0);
            check("stall_rdata", resp_rdata_o, 64'h11223344F0AB7788);
        end
        resp_ready_i = 1'b1;
        wait_idle();

        // Reset during ST_WR of a byte store: write suppressed, no response
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 64'h40;
        req_wdata_i  = 64'h77;
        check("rstst_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check("rstst_strd_addr", mem_addr_o, 64'h40);
        check("rstst_strd_wen", 64'(mem_wen_o), 64'd0);
        @(negedge clk_i);
        check("rstst_stwr_wen", 64'(mem_wen_o), 64'd1);
        check("rstst_stwr_wdata", mem_wdata_o, 64'h77);
        rst_i = 1'b1;
        #1 check("rstst_wen_gated", 64'(mem_wen_o), 64'd0);
        @(negedge clk_i);
        check("rstst_resp_valid", 64'(resp_valid_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rstst_req_ready", 64'(req_ready_o), 64'd1);
        req("LD_40_unwritten", 0, 3'b011, 64'h40, 64'h0, 0, 64'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
